// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART RX frame FIFO with exact fill level, almost-full and drop-oldest/newest overflow.
// Define UART_RX_FIFO_STATS_EN to implement the ovf_count/err_count statistics counters.
module uart_rx_fifo #(
  parameter int LOG2_DEPTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int OVERFLOW_MODE = 0
) (
  input  logic                  ifclk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_error,
  input  logic [LOG2_DEPTH:0]   afull_thresh,
  input  logic                  rd,
  output logic                  rd_valid,
  output logic [DATA_WIDTH:0]   rd_data,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  afull,
  output logic                  overflow,
  output logic [15:0]           ovf_count,
  output logic [15:0]           err_count
);

  localparam int                CW          = LOG2_DEPTH + 1;
  localparam int                DEPTH       = 1 << LOG2_DEPTH;
  localparam logic [CW-1:0]     DEPTH_C     = CW'(DEPTH);
  localparam bit                DROP_OLDEST = (OVERFLOW_MODE == 0);

  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH:0]   rd_data_q;
  logic                  push, pop, drop, wr_en, full_now, empty_now;

  always_comb begin
    push       = re;
    pop        = rd && rd_valid_q;
    full_now   = (count_q == DEPTH_C);
    empty_now  = (count_q == '0);
    drop       = push && full_now && !pop;
    wr_en      = push && !clear && (!drop || DROP_OLDEST);
    rp_d       = rp_q;
    wp_d       = wp_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (wr_en) wp_d = wp_q + 1'b1;
    // A drop-oldest overwrite retires the head just like a pop does.
    if (pop || (drop && DROP_OLDEST)) rp_d = rp_q + 1'b1;
    if (push && !pop && !full_now)    count_d = count_q + 1'b1;
    else if (pop && !push)            count_d = count_q - 1'b1;
    rd_valid_d = !empty_now && !pop && !(drop && DROP_OLDEST);
  end

  always_ff @(posedge ifclk) begin
    if (reset || clear) begin
      rp_q       <= '0;
      wp_q       <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      rp_q       <= rp_d;
      wp_q       <= wp_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= mem_q[rp_q];
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge ifclk) begin
    if (wr_en && !reset) mem_q[wp_q] <= {rx_error, rx_data};
  end

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] ovf_cnt_q, err_cnt_q;

  always_ff @(posedge ifclk) begin
    if (reset || clear) begin
      ovf_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (drop && !(&ovf_cnt_q)) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      if (pop && rd_data_q[DATA_WIDTH] && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign ovf_count = ovf_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign ovf_count = 16'h0;
  assign err_count = 16'h0;
`endif

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign afull    = (count_q >= afull_thresh);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo, both overflow modes against a queue model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, clear, re, rx_error;
  logic [7:0] rx_data;
  logic [4:0] thresh;
  logic [1:0] rd;
  logic [1:0] rv, emp, ful, af, ovf;
  logic [8:0] rdat [2];
  logic [4:0] cnt [2];
  logic [15:0] ovc [2];
  logic [15:0] erc [2];

  always #5 clk = ~clk;

  uart_rx_fifo #(.LOG2_DEPTH(4), .DATA_WIDTH(8), .OVERFLOW_MODE(0)) dut0 (
    .ifclk(clk), .reset(reset), .clear(clear), .re(re), .rx_data(rx_data), .rx_error(rx_error),
    .afull_thresh(thresh), .rd(rd[0]), .rd_valid(rv[0]), .rd_data(rdat[0]), .count(cnt[0]),
    .empty(emp[0]), .full(ful[0]), .afull(af[0]), .overflow(ovf[0]),
    .ovf_count(ovc[0]), .err_count(erc[0]));

  uart_rx_fifo #(.LOG2_DEPTH(4), .DATA_WIDTH(8), .OVERFLOW_MODE(1)) dut1 (
    .ifclk(clk), .reset(reset), .clear(clear), .re(re), .rx_data(rx_data), .rx_error(rx_error),
    .afull_thresh(thresh), .rd(rd[1]), .rd_valid(rv[1]), .rd_data(rdat[1]), .count(cnt[1]),
    .empty(emp[1]), .full(ful[1]), .afull(af[1]), .overflow(ovf[1]),
    .ovf_count(ovc[1]), .err_count(erc[1]));

  // Reference state: one frame queue per mode plus the flags the spec defines on top of it.
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  bit mval [2];
  bit movf [2];
  int movc [2];
  int merc [2];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int m);
    logic [8:0] q [$];
    logic [8:0] head;
    bit pop, isfull, drop;
    int sz;
    if (m == 0) q = q0; else q = q1;
    if (reset || clear) begin
      q.delete();
      mval[m] = 0; movf[m] = 0; movc[m] = 0; merc[m] = 0;
    end else begin
      sz     = q.size();
      pop    = rd[m] && mval[m];
      isfull = (sz == DEPTH);
      drop   = re && isfull && !pop;
      if (pop) begin
        head = q.pop_front();
        if (head[8] && merc[m] < 65535) merc[m]++;
      end
      if (re) begin
        if (!drop) q.push_back({rx_error, rx_data});
        else if (m == 0) begin
          void'(q.pop_front());
          q.push_back({rx_error, rx_data});
        end
      end
      if (drop) begin
        movf[m] = 1;
        if (movc[m] < 65535) movc[m]++;
      end
      mval[m] = (sz != 0) && !pop && !(drop && m == 0);
    end
    if (m == 0) q0 = q; else q1 = q;
  endtask

  task automatic check_all(input int m);
    int sz;
    logic [8:0] head;
    if (m == 0) begin sz = q0.size(); head = (sz > 0) ? q0[0] : 9'h0; end
    else begin sz = q1.size(); head = (sz > 0) ? q1[0] : 9'h0; end
    chk($sformatf("m%0d_rd_valid", m), rv[m], mval[m]);
    if (mval[m]) chk($sformatf("m%0d_rd_data", m), rdat[m], head);
    chk($sformatf("m%0d_count", m), cnt[m], sz);
    chk($sformatf("m%0d_empty", m), emp[m], sz == 0);
    chk($sformatf("m%0d_full", m), ful[m], sz == DEPTH);
    chk($sformatf("m%0d_afull", m), af[m], sz >= int'(thresh));
    chk($sformatf("m%0d_overflow", m), ovf[m], movf[m]);
    chk($sformatf("m%0d_ovf_count", m), ovc[m], STATS ? movc[m] : 0);
    chk($sformatf("m%0d_err_count", m), erc[m], STATS ? merc[m] : 0);
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all(0);
    check_all(1);
  endtask

  task automatic push(input logic [8:0] w);
    re = 1'b1; rx_error = w[8]; rx_data = w[7:0];
    tick();
    re = 1'b0;
  endtask

  task automatic pop_m(input int m, output logic [8:0] d);
    int n = 0;
    while (!mval[m] && n < 8) begin tick(); n++; end
    chk($sformatf("m%0d_pop_wait", m), mval[m], 1);
    d = rdat[m];
    rd[m] = 1'b1;
    tick();
    rd[m] = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [8:0] d;
    reset = 1'b1; clear = 1'b0; re = 1'b0; rx_error = 1'b0; rx_data = 8'h0;
    thresh = 5'd16; rd = 2'b00;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_count", cnt[0], 0);
    chk("reset_valid", rv[1], 0);

    push(9'h041);
    chk("lat_valid_t1", rv[0], 0);
    push(9'h042);
    chk("lat_valid_t2", rv[0], 1);
    push(9'h043);
    chk("three_count", cnt[0], 3);
    for (int m = 0; m < 2; m++) begin
      pop_m(m, d); chk("pop_41", d, 9'h041);
      pop_m(m, d); chk("pop_42", d, 9'h042);
      pop_m(m, d); chk("pop_43", d, 9'h043);
    end
    chk("three_empty", emp, 2'b11);

    do_clear();
    for (int i = 0; i <= 16; i++) push(9'(i));
    chk("ovf_count0", cnt[0], 16);
    chk("ovf_count1", cnt[1], 16);
    chk("ovf_flags", ovf, 2'b11);
    chk("ovf_stat0", ovc[0], STATS ? 1 : 0);
    for (int i = 0; i < 16; i++) begin pop_m(0, d); chk("m0_drop_oldest", d, 9'(i + 1)); end
    for (int i = 0; i < 16; i++) begin pop_m(1, d); chk("m1_drop_newest", d, 9'(i)); end
    chk("ovf_drained", emp, 2'b11);

    do_clear();
    for (int i = 0; i < 16; i++) push(9'(i));
    tick(); tick();
    chk("pp_both_valid", rv, 2'b11);
    re = 1'b1; rx_data = 8'h20; rx_error = 1'b0; rd = 2'b11;
    tick();
    re = 1'b0; rd = 2'b00;
    chk("pp_count0", cnt[0], 16);
    chk("pp_count1", cnt[1], 16);
    chk("pp_no_ovf", ovf, 2'b00);
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 16; i++) begin
        pop_m(m, d);
        chk("pp_order", d, (i < 15) ? 9'(i + 1) : 9'h020);
      end

    do_clear();
    thresh = 5'd1;
    tick();
    chk("afull_empty", af[0], 0);
    push(9'h155);
    chk("afull_one", af[0], 1);
    pop_m(0, d); chk("err_data0", d, 9'h155);
    pop_m(1, d); chk("err_data1", d, 9'h155);
    chk("err_stat0", erc[0], STATS ? 1 : 0);
    thresh = 5'd0;
    tick();
    chk("afull_thresh0", af, 2'b11);

    do_clear();
    for (int i = 0; i < 5; i++) push(9'(8'hA0 + i));
    clear = 1'b1; re = 1'b1; rx_data = 8'h77;
    tick();
    clear = 1'b0; re = 1'b0;
    chk("clr_count", cnt[0], 0);
    chk("clr_valid", rv, 2'b00);
    chk("clr_ovf", ovf, 2'b00);
    tick();
    chk("clr_not_stored", cnt[1], 0);

    for (int c = 0; c < 800; c++) begin
      re       = ($urandom_range(0, 9) < ((c / 100) % 2 ? 8 : 4));
      rx_data  = 8'($urandom);
      rx_error = ($urandom_range(0, 3) == 0);
      rd       = 2'($urandom);
      clear    = ($urandom_range(0, 79) == 0);
      if (c % 32 == 0) thresh = 5'($urandom_range(0, 16));
      tick();
    end
    re = 1'b0; rd = 2'b00; clear = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
